async_fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of async_fifo among NUM_REQ requesters in the wr_clk domain.

---
 rtl/async_fifo_pkg.sv | 12 +
 rtl/fifo_rr_picker.sv | 32 +++
 rtl/async_fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async_fifo write-side arbiter.
//   arb_state_e : arbiter FSM states
//   clog2_min1  : $clog2 clamped to a minimum of 1 (index widths)
package async_fifo_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker.
// Returns the first asserted request at or after rr_ptr, wrapping around.
//   req    in  NUM_REQ  request vector
//   rr_ptr in  ID_W     highest-priority index
//   found  out 1        any request asserted
//   idx    out ID_W     chosen index (0 when !found)
module fifo_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        int unsigned j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest offset back to rr_ptr so the nearest hit wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(rr_ptr) + (NUM_REQ - 1 - k)) % NUM_REQ;
            if (req[j]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter with packet lock in front of the async_fifo write port.
// A granted requester keeps the port until it sends a last beat, reaches MAX_BURST
// beats, or stays idle for GAP_TIMEOUT cycles. Every release spends one IDLE cycle.
//   wr_clk, wr_rst  write-domain clock, synchronous active-high reset
//   req_valid/data/last, req_ready  per-requester beat handshake
//   fifo_wr_en, fifo_wr_data, fifo_full  async_fifo write port
//   grant_valid, grant_id  current holder of the port
//   forced_release  1-cycle pulse after a MAX_BURST or GAP_TIMEOUT release
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned GAP_TIMEOUT = 8,
    localparam int unsigned ID_W       = clog2_min1(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id,
    output logic                          forced_release
);

    localparam int unsigned BC_W = $clog2(MAX_BURST + 1);
    localparam int unsigned GC_W = $clog2(GAP_TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [GC_W-1:0] gap_cnt_q, gap_cnt_d;
    logic            forced_q, forced_d;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    logic                  sel_valid, sel_last, xfer, rel;
    logic [DATA_WIDTH-1:0] sel_data;

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        sel_data  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        xfer      = (state_q == ARB_GRANT) && sel_valid && !fifo_full;
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        forced_d   = 1'b0;
        rel        = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d    = ARB_GRANT;
                    grant_id_d = pick_idx;
                end
            end
            ARB_GRANT: begin
                // A cycle stalled only by fifo_full touches neither counter.
                if (xfer) begin
                    gap_cnt_d = '0;
                    if (sel_last) begin
                        rel = 1'b1;
                    end else if (beat_cnt_q >= BC_W'(MAX_BURST - 1)) begin
                        rel      = 1'b1;
                        forced_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (!sel_valid) begin
                    if (gap_cnt_q >= GC_W'(GAP_TIMEOUT - 1)) begin
                        rel      = 1'b1;
                        forced_d = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                if (rel) begin
                    state_d    = ARB_IDLE;
                    rr_ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    beat_cnt_d = '0;
                    gap_cnt_d  = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            forced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            forced_q   <= forced_d;
        end
    end

    // Outputs are held at 0 while wr_rst is high so no beat leaks into the FIFO
    // during the reset cycle itself.
    always_comb begin
        req_ready      = '0;
        fifo_wr_en     = 1'b0;
        fifo_wr_data   = '0;
        grant_valid    = !wr_rst && (state_q == ARB_GRANT);
        grant_id       = grant_valid ? grant_id_q : '0;
        forced_release = !wr_rst && forced_q;
        if (grant_valid) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = xfer;
            fifo_wr_data          = sel_data;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
module tb_async_fifo_wr_arbiter;

    logic        wr_clk;
    logic        wr_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        forced_release;

    // {grant_valid, grant_id[1:0], req_ready[3:0], fifo_wr_en, forced_release}
    logic [8:0]  st;
    assign st = {grant_valid, grant_id, req_ready, fifo_wr_en, forced_release};

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        r;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        f;
        logic [8:0]  st;
        logic [7:0]  wd;
    } vec_t;

    logic [7:0] cap[$];

    async_fifo_wr_arbiter #(
        .NUM_REQ     (4),
        .DATA_WIDTH  (8),
        .MAX_BURST   (4),
        .GAP_TIMEOUT (3)
    ) dut (
        .wr_clk         (wr_clk),
        .wr_rst         (wr_rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .fifo_full      (fifo_full),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .forced_release (forced_release)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Record every beat written into the FIFO, sampled mid-cycle.
    always @(negedge wr_clk) if (fifo_wr_en) cap.push_back(fifo_wr_data);

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic [31:0] d, input logic f, input logic [8:0] s,
                                input logic [7:0] wd);
        vec_t t;
        t = '{r: r, v: v, l: l, d: d, f: f, st: s, wd: wd};
        return t;
    endfunction

    task automatic apply(input vec_t t);
        wr_rst    = t.r;
        req_valid = t.v;
        req_last  = t.l;
        req_data  = t.d;
        fifo_full = t.f;
    endtask

    localparam logic [8:0] S0  = 9'b0_00_0000_0_0;
    localparam logic [8:0] G0  = 9'b1_00_0001_1_0;
    localparam logic [8:0] G1  = 9'b1_01_0010_1_0;
    localparam logic [8:0] G2  = 9'b1_10_0100_1_0;
    localparam logic [8:0] G3  = 9'b1_11_1000_1_0;
    localparam logic [8:0] FRC = 9'b0_00_0000_0_1;

    task automatic test_reset();
        vec_t tv[$];
        logic [7:0] exp_q[$];
        cap.delete();
        tv.push_back(mk(1, 4'b1111, 4'b1111, 32'h3322_1100, 0, S0, 8'h00));
        tv.push_back(mk(1, 4'b1111, 4'b1111, 32'h3322_1100, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1111, 4'b1111, 32'h3322_1100, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1111, 4'b1111, 32'h3322_1100, 0, G0, 8'h00));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, S0, 8'h00));
        exp_q = '{8'h00};
        foreach (tv[k]) begin
            apply(tv[k]);
            #1;
            n_cmp++;
            if (st !== tv[k].st) begin
                n_bad++;
                $display("FAIL reset row%0d status got %b want %b", k, st, tv[k].st);
            end
            if (tv[k].st[1]) begin
                n_cmp++;
                if (fifo_wr_data !== tv[k].wd) begin
                    n_bad++;
                    $display("FAIL reset row%0d data got %h want %h", k, fifo_wr_data, tv[k].wd);
                end
            end
            @(posedge wr_clk); #1;
        end
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL reset beats got %0d want %0d", cap.size(), exp_q.size());
        end
    endtask

    task automatic test_two_packets();
        vec_t tv[$];
        logic [7:0] exp_q[$];
        cap.delete();
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0101, 4'b0000, 32'h00C0_00A0, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0101, 4'b0000, 32'h00C0_00A0, 0, G0, 8'hA0));
        tv.push_back(mk(0, 4'b0101, 4'b0001, 32'h00C0_00A1, 0, G0, 8'hA1));
        tv.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C0_0000, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C0_0000, 0, G2, 8'hC0));
        tv.push_back(mk(0, 4'b0100, 4'b0100, 32'h00C1_0000, 0, G2, 8'hC1));
        // rr_ptr is now 3: with req0 and req3 both valid, req3 must win.
        tv.push_back(mk(0, 4'b1001, 4'b1001, 32'h3D00_000D, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1001, 4'b1001, 32'h3D00_000D, 0, G3, 8'h3D));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        exp_q = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'h3D};
        foreach (tv[k]) begin
            apply(tv[k]);
            #1;
            n_cmp++;
            if (st !== tv[k].st) begin
                n_bad++;
                $display("FAIL two_pkt row%0d status got %b want %b", k, st, tv[k].st);
            end
            if (tv[k].st[1]) begin
                n_cmp++;
                if (fifo_wr_data !== tv[k].wd) begin
                    n_bad++;
                    $display("FAIL two_pkt row%0d data got %h want %h", k, fifo_wr_data, tv[k].wd);
                end
            end
            @(posedge wr_clk); #1;
        end
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL two_pkt beats got %0d want %0d", cap.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < cap.size()) begin
                n_cmp++;
                if (cap[k] !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL two_pkt beat%0d got %h want %h", k, cap[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        vec_t tv[$];
        logic [8:0] g[4];
        logic [7:0] exp_q[$];
        cap.delete();
        g = '{G0, G1, G2, G3};
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        for (int n = 0; n < 6; n++) begin
            tv.push_back(mk(0, 4'b1111, 4'b1111, 32'h3332_3130, 0, S0, 8'h00));
            tv.push_back(mk(0, 4'b1111, 4'b1111, 32'h3332_3130, 0, g[n % 4],
                            8'h30 + 8'(n % 4)));
        end
        tv.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30, 8'h31};
        foreach (tv[k]) begin
            apply(tv[k]);
            #1;
            n_cmp++;
            if (st !== tv[k].st) begin
                n_bad++;
                $display("FAIL rr row%0d status got %b want %b", k, st, tv[k].st);
            end
            if (tv[k].st[1]) begin
                n_cmp++;
                if (fifo_wr_data !== tv[k].wd) begin
                    n_bad++;
                    $display("FAIL rr row%0d data got %h want %h", k, fifo_wr_data, tv[k].wd);
                end
            end
            @(posedge wr_clk); #1;
        end
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL rr beats got %0d want %0d", cap.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < cap.size()) begin
                n_cmp++;
                if (cap[k] !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL rr beat%0d got %h want %h", k, cap[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        vec_t tv[$];
        logic [7:0] exp_q[$];
        cap.delete();
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_B000, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_B000, 0, G1, 8'hB0));
        for (int n = 0; n < 5; n++)
            tv.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_B100, 1, 9'b1_01_0000_0_0, 8'h00));
        tv.push_back(mk(0, 4'b0010, 4'b0000, 32'h0000_B100, 0, G1, 8'hB1));
        tv.push_back(mk(0, 4'b0010, 4'b0010, 32'h0000_B200, 0, G1, 8'hB2));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        exp_q = '{8'hB0, 8'hB1, 8'hB2};
        foreach (tv[k]) begin
            apply(tv[k]);
            #1;
            n_cmp++;
            if (st !== tv[k].st) begin
                n_bad++;
                $display("FAIL full row%0d status got %b want %b", k, st, tv[k].st);
            end
            if (tv[k].st[1]) begin
                n_cmp++;
                if (fifo_wr_data !== tv[k].wd) begin
                    n_bad++;
                    $display("FAIL full row%0d data got %h want %h", k, fifo_wr_data, tv[k].wd);
                end
            end
            @(posedge wr_clk); #1;
        end
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL full beats got %0d want %0d", cap.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < cap.size()) begin
                n_cmp++;
                if (cap[k] !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL full beat%0d got %h want %h", k, cap[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_max_burst();
        vec_t tv[$];
        logic [7:0] exp_q[$];
        cap.delete();
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1000, 4'b0000, 32'hD100_0000, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1001, 4'b0001, 32'hD100_00E0, 0, G3, 8'hD1));
        tv.push_back(mk(0, 4'b1001, 4'b0001, 32'hD200_00E0, 0, G3, 8'hD2));
        tv.push_back(mk(0, 4'b1001, 4'b0001, 32'hD300_00E0, 0, G3, 8'hD3));
        tv.push_back(mk(0, 4'b1001, 4'b0001, 32'hD400_00E0, 0, G3, 8'hD4));
        tv.push_back(mk(0, 4'b1001, 4'b0001, 32'hD500_00E0, 0, FRC, 8'h00));
        tv.push_back(mk(0, 4'b1001, 4'b0001, 32'hD500_00E0, 0, G0, 8'hE0));
        tv.push_back(mk(0, 4'b1000, 4'b0000, 32'hD500_0000, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1000, 4'b0000, 32'hD500_0000, 0, G3, 8'hD5));
        tv.push_back(mk(0, 4'b1000, 4'b1000, 32'hD600_0000, 0, G3, 8'hD6));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        exp_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hE0, 8'hD5, 8'hD6};
        foreach (tv[k]) begin
            apply(tv[k]);
            #1;
            n_cmp++;
            if (st !== tv[k].st) begin
                n_bad++;
                $display("FAIL burst row%0d status got %b want %b", k, st, tv[k].st);
            end
            if (tv[k].st[1]) begin
                n_cmp++;
                if (fifo_wr_data !== tv[k].wd) begin
                    n_bad++;
                    $display("FAIL burst row%0d data got %h want %h", k, fifo_wr_data, tv[k].wd);
                end
            end
            @(posedge wr_clk); #1;
        end
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL burst beats got %0d want %0d", cap.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < cap.size()) begin
                n_cmp++;
                if (cap[k] !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL burst beat%0d got %h want %h", k, cap[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_gap_and_reset();
        vec_t tv[$];
        logic [7:0] exp_q[$];
        cap.delete();
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(1, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0100, 4'b0000, 32'h00F0_0000, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b0100, 4'b0000, 32'h00F0_0000, 0, G2, 8'hF0));
        for (int n = 0; n < 3; n++)
            tv.push_back(mk(0, 4'b1000, 4'b0000, 32'h3F00_0000, 0, 9'b1_10_0100_0_0, 8'h00));
        tv.push_back(mk(0, 4'b1000, 4'b0000, 32'h3F00_0000, 0, FRC, 8'h00));
        tv.push_back(mk(0, 4'b1000, 4'b0000, 32'h3F00_0000, 0, G3, 8'h3F));
        // Reset in the middle of req3's packet.
        tv.push_back(mk(1, 4'b1000, 4'b0000, 32'h4000_0000, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1000, 4'b0000, 32'h4000_0000, 0, S0, 8'h00));
        tv.push_back(mk(0, 4'b1000, 4'b0000, 32'h4000_0000, 0, G3, 8'h40));
        tv.push_back(mk(0, 4'b1000, 4'b1000, 32'h4100_0000, 0, G3, 8'h41));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, S0, 8'h00));
        exp_q = '{8'hF0, 8'h3F, 8'h40, 8'h41};
        foreach (tv[k]) begin
            apply(tv[k]);
            #1;
            n_cmp++;
            if (st !== tv[k].st) begin
                n_bad++;
                $display("FAIL gap row%0d status got %b want %b", k, st, tv[k].st);
            end
            if (tv[k].st[1]) begin
                n_cmp++;
                if (fifo_wr_data !== tv[k].wd) begin
                    n_bad++;
                    $display("FAIL gap row%0d data got %h want %h", k, fifo_wr_data, tv[k].wd);
                end
            end
            @(posedge wr_clk); #1;
        end
        n_cmp++;
        if (cap.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL gap beats got %0d want %0d", cap.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            if (k < cap.size()) begin
                n_cmp++;
                if (cap[k] !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL gap beat%0d got %h want %h", k, cap[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        wr_rst    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        test_reset();
        test_two_packets();
        test_round_robin();
        test_fifo_full();
        test_max_burst();
        test_gap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
